// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared opcode/func constants, writeback encoding and control-word type
package proc_ctrl_pkg;

  localparam int CW_ALUOP_W = 5;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] OPC_ADDI  = 5'b00101;
  localparam logic [4:0] OPC_SW    = 5'b00111;
  localparam logic [4:0] OPC_LW    = 5'b01000;

  localparam logic [4:0] FN_ADD = 5'b00000;
  localparam logic [4:0] FN_SUB = 5'b00001;
  localparam logic [4:0] FN_AND = 5'b00010;
  localparam logic [4:0] FN_OR  = 5'b00011;
  localparam logic [4:0] FN_SLL = 5'b00100;
  localparam logic [4:0] FN_SRA = 5'b00101;
  localparam logic [4:0] FN_MUL = 5'b00110;
  localparam logic [4:0] FN_DIV = 5'b00111;

  localparam logic [2:0] STAT_MUL_EXC = 3'd4;
  localparam logic [2:0] STAT_DIV_EXC = 3'd5;

  typedef enum logic [1:0] {
    RWD_ALU    = 2'b00,
    RWD_DMEM   = 2'b01,
    RWD_MD     = 2'b10,
    RWD_STATUS = 2'b11
  } rwd_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MD_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                  dm_we;
    logic                  r_we;
    rwd_t                  rwd;
    logic [CW_ALUOP_W-1:0] alu_op;
    logic                  alu_in_b;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - pure opcode/func to control-word decode
// mul/div funcs are recognised only when CTRL_MULDIV_EN is defined; otherwise they are illegal.
module ctrl_decode_comb
  import proc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 5
) (
  input  logic [OPC_W-1:0]   opcode,
  input  logic [ALUOP_W-1:0] func,
  output ctrl_word_t         cw,
  output logic               is_md,
  output logic               md_div,
  output logic               illegal
);

  always_comb begin
    cw      = '0;
    is_md   = 1'b0;
    md_div  = 1'b0;
    illegal = 1'b0;
    if (opcode == OPC_W'(OPC_RTYPE)) begin
      if (func <= ALUOP_W'(FN_SRA)) begin
        cw.r_we   = 1'b1;
        cw.rwd    = RWD_ALU;
        cw.alu_op = CW_ALUOP_W'(func);
      end
`ifdef CTRL_MULDIV_EN
      else if (func == ALUOP_W'(FN_MUL) || func == ALUOP_W'(FN_DIV)) begin
        is_md  = 1'b1;
        md_div = func[0];
      end
`endif
      else begin
        illegal = 1'b1;
      end
    end else if (opcode == OPC_W'(OPC_ADDI)) begin
      cw.r_we     = 1'b1;
      cw.alu_in_b = 1'b1;
    end else if (opcode == OPC_W'(OPC_SW)) begin
      cw.dm_we    = 1'b1;
      cw.alu_in_b = 1'b1;
    end else if (opcode == OPC_W'(OPC_LW)) begin
      cw.r_we     = 1'b1;
      cw.rwd      = RWD_DMEM;
      cw.alu_in_b = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_seq_decoder.sv
// rtl/ctrl_seq_decoder.sv - registered control decode with mult/div sequencing and timeout
// CTRL_MULDIV_EN enables mul/div decode, the MD_WAIT state and the timeout counter.
module ctrl_seq_decoder
  import proc_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 5,
  parameter int OPC_W      = 5,
  parameter int MD_TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               insn_valid,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [ALUOP_W-1:0] alu_op_in,
  output logic               insn_ready,
  input  logic               md_ready,
  input  logic               md_exception,
  output logic               ctrl_valid,
  output logic               DMwe,
  output logic               Rwe,
  output logic [1:0]         Rwd,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               ALUinB,
  output logic               rd_override,
  output logic [2:0]         status_code,
  output logic               md_start,
  output logic               md_sel,
  output logic               stall,
  output logic               illegal
);

  ctrl_word_t dec_cw;
  logic       dec_is_md;
  logic       dec_md_div;
  logic       dec_illegal;

  ctrl_decode_comb #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W)) u_decode (
    .opcode  (opcode),
    .func    (alu_op_in),
    .cw      (dec_cw),
    .is_md   (dec_is_md),
    .md_div  (dec_md_div),
    .illegal (dec_illegal)
  );

  logic accept;
  logic md_launch;
  logic md_done;
  logic md_fail;
  logic md_sel_d;
  logic md_sel_q;

  assign accept = insn_valid && insn_ready;

`ifdef CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // md_ready takes priority over the timeout when both land on the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done   = 1'b0;
    md_fail   = 1'b0;
    md_launch = 1'b0;
    md_sel_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && dec_is_md) begin
          md_launch = 1'b1;
          md_sel_d  = dec_md_div;
          state_d   = S_MD_WAIT;
          cnt_d     = '0;
        end
      end
      S_MD_WAIT: begin
        if (md_ready || cnt_q == CNT_MAX) begin
          md_done = 1'b1;
          md_fail = md_ready ? md_exception : 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          md_sel_d = md_sel_q;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign insn_ready = (state_q == S_IDLE);
`else
  logic unused_md;
  assign unused_md  = md_ready ^ md_exception ^ dec_md_div ^ (MD_TIMEOUT > 1);
  assign insn_ready = 1'b1;
  assign md_launch  = 1'b0;
  assign md_done    = 1'b0;
  assign md_fail    = 1'b0;
  assign md_sel_d   = 1'b0;
`endif

  assign stall = !insn_ready;

  ctrl_word_t cw_d, cw_q;
  logic       valid_d, illegal_d, rd_ovr_d;
  logic [2:0] status_d;

  always_comb begin
    cw_d      = '0;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    rd_ovr_d  = 1'b0;
    status_d  = 3'd0;
    if (md_done) begin
      valid_d   = 1'b1;
      cw_d.r_we = 1'b1;
      if (md_fail) begin
        cw_d.rwd = RWD_STATUS;
        rd_ovr_d = 1'b1;
        status_d = md_sel_q ? STAT_DIV_EXC : STAT_MUL_EXC;
      end else begin
        cw_d.rwd = RWD_MD;
      end
    end else if (accept && !dec_is_md) begin
      valid_d   = 1'b1;
      cw_d      = dec_cw;
      illegal_d = dec_illegal;
    end
  end

  logic       valid_q, illegal_q, rd_ovr_q, md_start_q;
  logic [2:0] status_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cw_q       <= '0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      rd_ovr_q   <= 1'b0;
      status_q   <= 3'd0;
      md_start_q <= 1'b0;
      md_sel_q   <= 1'b0;
    end else begin
      cw_q       <= cw_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      rd_ovr_q   <= rd_ovr_d;
      status_q   <= status_d;
      md_start_q <= md_launch;
      md_sel_q   <= md_sel_d;
    end
  end

  assign ctrl_valid  = valid_q;
  assign DMwe        = cw_q.dm_we;
  assign Rwe         = cw_q.r_we;
  assign Rwd         = cw_q.rwd;
  assign ALUop       = ALUOP_W'(cw_q.alu_op);
  assign ALUinB      = cw_q.alu_in_b;
  assign rd_override = rd_ovr_q;
  assign status_code = status_q;
  assign md_start    = md_start_q;
  assign md_sel      = md_sel_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// tb/tb_ctrl_seq_decoder.sv - directed vector table plus multi-cycle mul/div sequences
module tb_ctrl_seq_decoder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       insn_valid;
  logic [4:0] opcode;
  logic [4:0] alu_op_in;
  logic       insn_ready;
  logic       md_ready;
  logic       md_exception;
  logic       ctrl_valid, DMwe, Rwe, ALUinB, rd_override, md_start, md_sel, stall, illegal;
  logic [1:0] Rwd;
  logic [4:0] ALUop;
  logic [2:0] status_code;

  ctrl_seq_decoder #(.ALUOP_W(5), .OPC_W(5), .MD_TIMEOUT(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .insn_valid   (insn_valid),
    .opcode       (opcode),
    .alu_op_in    (alu_op_in),
    .insn_ready   (insn_ready),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .ctrl_valid   (ctrl_valid),
    .DMwe         (DMwe),
    .Rwe          (Rwe),
    .Rwd          (Rwd),
    .ALUop        (ALUop),
    .ALUinB       (ALUinB),
    .rd_override  (rd_override),
    .status_code  (status_code),
    .md_start     (md_start),
    .md_sel       (md_sel),
    .stall        (stall),
    .illegal      (illegal)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  opc;
    logic [4:0]  fn;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // {ctrl_valid, DMwe, Rwe, Rwd, ALUop, ALUinB, illegal, rd_override, status_code, md_start}
  function automatic logic [16:0] obs();
    return {ctrl_valid, DMwe, Rwe, Rwd, ALUop, ALUinB, illegal, rd_override, status_code, md_start};
  endfunction

  function automatic logic [16:0] ex(input logic v, input logic dm, input logic rwe,
                                     input logic [1:0] rwd, input logic [4:0] op,
                                     input logic b, input logic ill);
    return {v, dm, rwe, rwd, op, b, ill, 1'b0, 3'd0, 1'b0};
  endfunction

  function automatic logic [16:0] ex_md(input logic [1:0] rwd, input logic ovr, input logic [2:0] st);
    return {1'b1, 1'b0, 1'b1, rwd, 5'd0, 1'b0, 1'b0, ovr, st, 1'b0};
  endfunction

  task automatic issue(input logic [4:0] opc, input logic [4:0] fn);
    insn_valid = 1'b1;
    opcode     = opc;
    alu_op_in  = fn;
    step();
    insn_valid = 1'b0;
  endtask

  initial begin
    int sc;
    int ms;
    int n;
    int cv;

    vecs.push_back('{5'd0,  5'd0, ex(1, 0, 1, 2'b00, 5'd0, 0, 0)});
    vecs.push_back('{5'd0,  5'd1, ex(1, 0, 1, 2'b00, 5'd1, 0, 0)});
    vecs.push_back('{5'd0,  5'd2, ex(1, 0, 1, 2'b00, 5'd2, 0, 0)});
    vecs.push_back('{5'd0,  5'd3, ex(1, 0, 1, 2'b00, 5'd3, 0, 0)});
    vecs.push_back('{5'd0,  5'd4, ex(1, 0, 1, 2'b00, 5'd4, 0, 0)});
    vecs.push_back('{5'd0,  5'd5, ex(1, 0, 1, 2'b00, 5'd5, 0, 0)});
    vecs.push_back('{5'd5,  5'd3, ex(1, 0, 1, 2'b00, 5'd0, 1, 0)});
    vecs.push_back('{5'd7,  5'd0, ex(1, 1, 0, 2'b00, 5'd0, 1, 0)});
    vecs.push_back('{5'd8,  5'd0, ex(1, 0, 1, 2'b01, 5'd0, 1, 0)});
    vecs.push_back('{5'd31, 5'd0, ex(1, 0, 0, 2'b00, 5'd0, 0, 1)});
    vecs.push_back('{5'd0,  5'd8, ex(1, 0, 0, 2'b00, 5'd0, 0, 1)});
    vecs.push_back('{5'd1,  5'd0, ex(1, 0, 0, 2'b00, 5'd0, 0, 1)});
`ifndef CTRL_MULDIV_EN
    vecs.push_back('{5'd0,  5'd6, ex(1, 0, 0, 2'b00, 5'd0, 0, 1)});
    vecs.push_back('{5'd0,  5'd7, ex(1, 0, 0, 2'b00, 5'd0, 0, 1)});
`endif

    reset_n      = 1'b0;
    insn_valid   = 1'b0;
    opcode       = 5'd0;
    alu_op_in    = 5'd0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    step();
    step();
    chk("reset_outputs", 32'(obs()), 32'd0);
    chk("reset_insn_ready", 32'(insn_ready), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_md_sel", 32'(md_sel), 32'd0);
    reset_n = 1'b1;
    step();

    // Back-to-back accepts: every vector is presented on consecutive cycles.
    for (int i = 0; i < vecs.size(); i++) begin
      insn_valid = 1'b1;
      opcode     = vecs[i].opc;
      alu_op_in  = vecs[i].fn;
      step();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_ready", i), 32'(insn_ready), 32'd1);
    end
    insn_valid = 1'b0;
    opcode     = 5'd8;
    step();
    chk("idle_no_accept", 32'(obs()), 32'd0);

`ifdef CTRL_MULDIV_EN
    // mul with md_ready five cycles after md_start
    issue(5'd0, 5'd6);
    chk("mul_start", 32'({md_start, md_sel, ctrl_valid}), 32'b100);
    sc = int'(stall);
    ms = int'(md_start);
    for (int c = 2; c <= 6; c++) begin
      step();
      sc += int'(stall);
      ms += int'(md_start);
    end
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    sc += int'(stall);
    ms += int'(md_start);
    chk("mul_done", 32'(obs()), 32'(ex_md(2'b10, 1'b0, 3'd0)));
    chk("mul_stall_cycles", 32'(sc), 32'd6);
    chk("mul_start_pulses", 32'(ms), 32'd1);
    step();
    chk("mul_ready_after", 32'({insn_ready, ctrl_valid}), 32'b10);

    // div exception reported together with md_ready
    issue(5'd0, 5'd7);
    chk("div_start", 32'({md_start, md_sel}), 32'b11);
    md_ready     = 1'b1;
    md_exception = 1'b1;
    step();
    md_ready     = 1'b0;
    md_exception = 1'b0;
    chk("div_exc", 32'(obs()), 32'(ex_md(2'b11, 1'b1, 3'd5)));

    // mul timeout: no md_ready at all
    issue(5'd0, 5'd6);
    n = 0;
    while (ctrl_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd8);
    chk("timeout_exc", 32'(obs()), 32'(ex_md(2'b11, 1'b1, 3'd4)));
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    chk("late_ready_ignored", 32'({ctrl_valid, insn_ready, md_start}), 32'b010);

    // md_ready on the last counter cycle beats the timeout
    issue(5'd0, 5'd7);
    for (int c = 2; c <= 8; c++) step();
    chk("edge_not_yet_done", 32'({ctrl_valid, stall}), 32'b01);
    md_ready = 1'b1;
    step();
    md_ready = 1'b0;
    chk("edge_ready_wins", 32'(obs()), 32'(ex_md(2'b10, 1'b0, 3'd0)));

    // reset mid-MD_WAIT
    issue(5'd0, 5'd6);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'({insn_ready, stall, ctrl_valid}), 32'b100);
    step();
    reset_n = 1'b1;
    cv = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      cv += int'(ctrl_valid);
    end
    chk("rst_no_valid", 32'(cv), 32'd0);
    chk("rst_idle", 32'({insn_ready, md_sel}), 32'b10);
`else
    // mult/div disabled: md_ready is ignored and the decoder never stalls
    issue(5'd0, 5'd6);
    md_ready = 1'b1;
    chk("nomd_no_start", 32'({md_start, md_sel, insn_ready}), 32'b001);
    step();
    md_ready = 1'b0;
    chk("nomd_ready_ignored", 32'({ctrl_valid, stall}), 32'b00);
`endif

    issue(5'd0, 5'd1);
    chk("final_sub", 32'(obs()), 32'(ex(1, 0, 1, 2'b00, 5'd1, 0, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
